// File: rtl/bcnt_pkg.sv
// Shared encodings for the parametrised bounded up/down counter.
package bcnt_pkg;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  typedef enum logic {
    MODE_WRAP = 1'b0,
    MODE_SAT  = 1'b1
  } mode_e;

endpackage

// File: rtl/bcnt_next.sv
// Combinational next-count / terminal-count calculator for bcnt_param.
// Arithmetic is done one bit wider than the counter so sums and spans never alias.
module bcnt_next
  import bcnt_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] count,
  input  dir_e             dir,
  input  mode_e            mode,
  input  logic [WIDTH-1:0] step,
  input  logic [WIDTH-1:0] lim_lo,
  input  logic [WIDTH-1:0] lim_hi,
  output logic [WIDTH-1:0] nxt,
  output logic             tc_nxt
);

  localparam logic [WIDTH:0] ONE = (WIDTH+1)'(1);

  logic [WIDTH:0] w_cnt;
  logic [WIDTH:0] w_lo;
  logic [WIDTH:0] w_hi;
  logic [WIDTH:0] w_step;
  logic [WIDTH:0] w_span;
  logic [WIDTH:0] w_eff;
  logic [WIDTH:0] w_sum;
  logic [WIDTH:0] w_diff;

  assign w_cnt  = {1'b0, count};
  assign w_lo   = {1'b0, lim_lo};
  assign w_hi   = {1'b0, lim_hi};
  assign w_step = {1'b0, step};
  assign w_span = w_hi - w_lo + ONE;
  assign w_eff  = (w_step < w_span) ? w_step : w_span;
  assign w_sum  = w_cnt + w_eff;
  assign w_diff = w_cnt - w_lo;

  always_comb begin
    nxt    = count;
    tc_nxt = 1'b0;
    // Bounds moved under the counter: snap to the bound we are heading away from.
    if ((w_cnt < w_lo) || (w_cnt > w_hi)) begin
      nxt = (dir == DIR_DOWN) ? lim_hi : lim_lo;
    end else if (w_step != '0) begin
      if (dir == DIR_UP) begin
        if (w_sum <= w_hi) begin
          nxt = WIDTH'(w_sum);
        end else begin
          tc_nxt = 1'b1;
          nxt    = (mode == MODE_SAT) ? lim_hi : WIDTH'(w_lo + (w_sum - w_hi - ONE));
        end
      end else begin
        if (w_diff >= w_eff) begin
          nxt = WIDTH'(w_cnt - w_eff);
        end else begin
          tc_nxt = 1'b1;
          nxt    = (mode == MODE_SAT) ? lim_lo : WIDTH'(w_hi - (w_eff - w_diff - ONE));
        end
      end
    end
  end

endmodule

// File: rtl/bcnt_param.sv
// Parametrised up/down counter with run-time bounds, step, wrap/saturate,
// synchronous load, terminal-count pulse and sticky overflow.
module bcnt_param
  import bcnt_pkg::*;
#(
  parameter int unsigned     WIDTH   = 4,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             dir,
  input  logic             mode_sat,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] step,
  input  logic [WIDTH-1:0] lim_lo,
  input  logic [WIDTH-1:0] lim_hi,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             ovf,
  output logic             cfg_err
);

  logic [WIDTH-1:0] r_count;
  logic             r_tc;
  logic             r_ovf;

  logic [WIDTH-1:0] w_nxt;
  logic             w_tc_nxt;
  logic [WIDTH-1:0] w_load_cl;
  logic             w_tc_d;

  bcnt_next #(
    .WIDTH(WIDTH)
  ) u_next (
    .count  (r_count),
    .dir    (dir_e'(dir)),
    .mode   (mode_e'(mode_sat)),
    .step   (step),
    .lim_lo (lim_lo),
    .lim_hi (lim_hi),
    .nxt    (w_nxt),
    .tc_nxt (w_tc_nxt)
  );

  assign cfg_err = (lim_lo > lim_hi);

  always_comb begin
    w_load_cl = load_val;
    if (load_val < lim_lo) begin
      w_load_cl = lim_lo;
    end else if (load_val > lim_hi) begin
      w_load_cl = lim_hi;
    end
  end

  // tc only comes from an enabled count step; cfg_err and load both mask it.
  assign w_tc_d = ~cfg_err & ~load & en & w_tc_nxt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= RST_VAL;
      r_tc    <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_tc  <= w_tc_d;
      r_ovf <= w_tc_d | (r_ovf & ~clr_ovf);
      if (!cfg_err) begin
        if (load) begin
          r_count <= w_load_cl;
        end else if (en) begin
          r_count <= w_nxt;
        end
      end
    end
  end

  assign count = r_count;
  assign tc    = r_tc;
  assign ovf   = r_ovf;

endmodule

// File: tb/tb_bcnt_param.sv
// Self-checking bench for bcnt_param: directed scenarios plus randomized
// stimulus against an integer-arithmetic reference model.
module tb_bcnt_param;

  logic       clk = 1'b0;
  logic       rst;
  logic       en, dir, mode_sat, load, clr_ovf;
  logic [3:0] load_val, step, lim_lo, lim_hi;
  logic [3:0] count;
  logic       tc, ovf, cfg_err;

  int checks = 0;
  int errors = 0;

  int m_count = 0;
  bit m_tc    = 1'b0;
  bit m_ovf   = 1'b0;

  bcnt_param #(
    .WIDTH  (4),
    .RST_VAL(4'd0)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .dir     (dir),
    .mode_sat(mode_sat),
    .load    (load),
    .load_val(load_val),
    .step    (step),
    .lim_lo  (lim_lo),
    .lim_hi  (lim_hi),
    .clr_ovf (clr_ovf),
    .count   (count),
    .tc      (tc),
    .ovf     (ovf),
    .cfg_err (cfg_err)
  );

  always #5 clk = ~clk;

  // Advance one clock; the reference model consumes the inputs present before the edge.
  task automatic cycle();
    int c, lo, hi, st, span, eff;
    bit t;
    c  = m_count;
    lo = int'(lim_lo);
    hi = int'(lim_hi);
    st = int'(step);
    t  = 1'b0;
    if (lo > hi) begin
      c = m_count;
    end else if (load) begin
      c = (int'(load_val) < lo) ? lo : (int'(load_val) > hi) ? hi : int'(load_val);
    end else if (en) begin
      if (c < lo || c > hi) begin
        c = dir ? hi : lo;
      end else if (st != 0) begin
        span = hi - lo + 1;
        eff  = (st < span) ? st : span;
        if (!dir) begin
          if (c + eff > hi) begin
            t = 1'b1;
            c = mode_sat ? hi : lo + ((c - lo + eff) % span);
          end else c = c + eff;
        end else begin
          if (c - eff < lo) begin
            t = 1'b1;
            c = mode_sat ? lo : lo + (((c - lo - eff) % span) + span) % span;
          end else c = c - eff;
        end
      end
    end
    @(posedge clk);
    #1;
    if (rst) begin
      m_count = c;
      m_tc    = t;
      m_ovf   = t | (m_ovf & !clr_ovf);
    end
  endtask

  task automatic set_cfg(input int lo, input int hi, input int st, input bit d, input bit sat);
    lim_lo   = 4'(lo);
    lim_hi   = 4'(hi);
    step     = 4'(st);
    dir      = d;
    mode_sat = sat;
  endtask

  task automatic do_load(input int v);
    load     = 1'b1;
    load_val = 4'(v);
    cycle();
    load     = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; en = 1'b0; load = 1'b0; clr_ovf = 1'b0; load_val = '0;
    set_cfg(0, 15, 1, 1'b0, 1'b0);
    #12;
    checks++;
    if (count !== 4'd0 || tc !== 1'b0 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold count=%0d tc=%0b ovf=%0b want 0/0/0", count, tc, ovf);
    end
    rst = 1'b1;
    m_count = 0; m_tc = 1'b0; m_ovf = 1'b0;
    en = 1'b1;
    repeat (5) cycle();
    checks++;
    if (count !== 4'd5) begin
      errors++;
      $display("FAIL reset_precount count=%0d want 5", count);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (count !== 4'd0 || tc !== 1'b0 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset_async count=%0d tc=%0b ovf=%0b want 0/0/0", count, tc, ovf);
    end
    en = 1'b0;
    m_count = 0; m_tc = 1'b0; m_ovf = 1'b0;
    #1 rst = 1'b1;
  endtask

  task automatic test_up_wrap();
    set_cfg(0, 9, 1, 1'b0, 1'b0);
    do_load(0);
    en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cycle();
      checks++;
      if (count !== 4'((i + 1) % 10) || tc !== (i == 9)) begin
        errors++;
        $display("FAIL up_wrap[%0d] count=%0d tc=%0b want %0d/%0b", i, count, tc, (i + 1) % 10, i == 9);
      end
    end
    en = 1'b0;
    checks++;
    if (ovf !== 1'b1) begin
      errors++;
      $display("FAIL up_wrap_ovf ovf=%0b want 1", ovf);
    end
  endtask

  task automatic test_step_wrap();
    set_cfg(0, 9, 3, 1'b0, 1'b0);
    do_load(8);
    en = 1'b1;
    cycle();
    checks++;
    if (count !== 4'd1 || tc !== 1'b1) begin
      errors++;
      $display("FAIL step_wrap count=%0d tc=%0b want 1/1", count, tc);
    end
    cycle();
    checks++;
    if (count !== 4'd4 || tc !== 1'b0) begin
      errors++;
      $display("FAIL step_next count=%0d tc=%0b want 4/0", count, tc);
    end
    en = 1'b0;
  endtask

  task automatic test_down_sat();
    int exp_c[4] = '{3, 2, 2, 2};
    bit exp_t[4] = '{1'b0, 1'b1, 1'b1, 1'b1};
    set_cfg(2, 12, 2, 1'b1, 1'b1);
    do_load(5);
    en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cycle();
      checks++;
      if (count !== 4'(exp_c[i]) || tc !== exp_t[i]) begin
        errors++;
        $display("FAIL down_sat[%0d] count=%0d tc=%0b want %0d/%0b", i, count, tc, exp_c[i], exp_t[i]);
      end
    end
    en = 1'b0;
  endtask

  task automatic test_load();
    set_cfg(2, 12, 1, 1'b0, 1'b0);
    en = 1'b1;
    do_load(14);
    checks++;
    if (count !== 4'd12 || tc !== 1'b0) begin
      errors++;
      $display("FAIL load_clamp_hi count=%0d tc=%0b want 12/0", count, tc);
    end
    do_load(0);
    checks++;
    if (count !== 4'd2 || tc !== 1'b0) begin
      errors++;
      $display("FAIL load_clamp_lo count=%0d tc=%0b want 2/0", count, tc);
    end
    en = 1'b0;
  endtask

  task automatic test_err_ovf();
    set_cfg(9, 3, 1, 1'b0, 1'b0);
    #1;
    checks++;
    if (cfg_err !== 1'b1) begin
      errors++;
      $display("FAIL cfg_err flag=%0b want 1", cfg_err);
    end
    en = 1'b1;
    cycle();
    do_load(5);
    checks++;
    if (count !== 4'd2 || tc !== 1'b0) begin
      errors++;
      $display("FAIL cfg_err_hold count=%0d tc=%0b want 2/0", count, tc);
    end
    en = 1'b0;
    set_cfg(0, 9, 1, 1'b0, 1'b0);
    do_load(9);
    en = 1'b1;
    clr_ovf = 1'b1;
    cycle();
    checks++;
    if (count !== 4'd0 || tc !== 1'b1 || ovf !== 1'b1) begin
      errors++;
      $display("FAIL ovf_set_wins count=%0d tc=%0b ovf=%0b want 0/1/1", count, tc, ovf);
    end
    cycle();
    clr_ovf = 1'b0;
    en = 1'b0;
    checks++;
    if (ovf !== 1'b0 || count !== 4'd1) begin
      errors++;
      $display("FAIL ovf_clear ovf=%0b count=%0d want 0/1", ovf, count);
    end
  endtask

  task automatic test_random();
    int lo, hi, tmp;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(9) == 0) begin
        lo = $urandom_range(15);
        hi = $urandom_range(15);
        if (lo > hi && $urandom_range(4) != 0) begin
          tmp = lo; lo = hi; hi = tmp;
        end
        if ($urandom_range(7) == 0) begin
          lo = 0; hi = 15;
        end
        lim_lo = 4'(lo);
        lim_hi = 4'(hi);
      end
      en       = ($urandom_range(7) != 0);
      load     = ($urandom_range(7) == 0);
      load_val = 4'($urandom_range(15));
      step     = 4'($urandom_range(15));
      dir      = 1'($urandom_range(1));
      mode_sat = 1'($urandom_range(1));
      clr_ovf  = ($urandom_range(5) == 0);
      #1;
      checks++;
      if (cfg_err !== (lim_lo > lim_hi)) begin
        errors++;
        $display("FAIL rand_cfg_err[%0d] got=%0b want=%0b", i, cfg_err, lim_lo > lim_hi);
      end
      cycle();
      checks++;
      if (count !== 4'(m_count) || tc !== m_tc || ovf !== m_ovf) begin
        errors++;
        $display("FAIL rand[%0d] count=%0d tc=%0b ovf=%0b want %0d/%0b/%0b",
                 i, count, tc, ovf, m_count, m_tc, m_ovf);
      end
    end
    en = 1'b0; load = 1'b0; clr_ovf = 1'b0;
  endtask

  initial begin
    test_reset();
    test_up_wrap();
    test_step_wrap();
    test_down_sat();
    test_load();
    test_err_ovf();
    set_cfg(0, 15, 1, 1'b0, 1'b0);
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
